alu_mdu_ex: RTL and testbench

Parametrised EX-stage ALU for the MIPS pipeline, successor to the single-cycle R-type ALU. Keeps single-cycle R-type ops (result valid same cycle, feeding the EX/MEM register) and adds an iterative multiply/divide unit with architectural HI/LO registers. While a multi-cycle operation or a dependent HI/LO access is pending, it raises a stall toward the hazard unit.

---
 rtl/alu_ex_pkg.sv | 46 ++++
 rtl/alu_mdu_iter.sv | 162 ++++++++++++++++
 rtl/alu_mdu_ex.sv | 97 +++++++++
 tb/tb_alu_mdu_ex.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ex_pkg.sv
// rtl/alu_ex_pkg.sv - funct codes, MDU state enum and funct classifiers for the EX-stage ALU
package alu_ex_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_t;

    // Ops that start the iterative unit.
    function automatic logic is_iter_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    // Ops that touch HI/LO or the iterative unit and must wait while it runs.
    function automatic logic is_hilo_funct(input logic [5:0] f);
        return is_iter_funct(f) || (f == F_MFHI) || (f == F_MFLO) ||
               (f == F_MTHI) || (f == F_MTLO);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - iterative shift-add multiplier / restoring divider owning HI and LO
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             launch an iterative op (only honoured when idle)
//   is_div, is_signed op select: multiply/divide, signed/unsigned
//   op_a, op_b        rs / rt operands (dividend / divisor for divides)
//   mthi, mtlo, wdata direct HI/LO writes
//   busy              iteration in progress
//   hi, lo            architectural HI/LO
module alu_mdu_iter
    import alu_ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t       state, state_next;
    logic [CW-1:0]    cnt;
    // acc: upper product half / partial remainder.
    // quo: multiplier bits being consumed / dividend bits shifting out, quotient shifting in.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;

    logic             start_sign_a;
    logic             start_sign_b;
    logic [WIDTH-1:0] start_mag_a;
    logic [WIDTH-1:0] start_mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem_n;
    logic [WIDTH-1:0]   div_quo_n;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_iter;

    assign busy      = (state != IDLE);
    assign last_iter = (cnt == CW'(1));

    // Operands are iterated as magnitudes; signs are reapplied at writeback.
    always_comb begin
        start_sign_a = is_signed && op_a[WIDTH-1];
        start_sign_b = is_signed && op_b[WIDTH-1];
        start_mag_a  = start_sign_a ? (~op_a + 1'b1) : op_a;
        start_mag_b  = start_sign_b ? (~op_b + 1'b1) : op_b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], quo[WIDTH-1:1]};

        // The remainder stays below the divisor, so the borrow lands in bit WIDTH.
        div_shift = {acc, quo[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_b};
        div_ok    = !div_trial[WIDTH];
        div_rem_n = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_n = {quo[WIDTH-2:0], div_ok};

        prod_mag  = {mul_hi_n, mul_lo_n};
        prod_fix  = (sign_a ^ sign_b) ? (~prod_mag + 1'b1) : prod_mag;
        // With a zero divisor the remainder path passes the dividend magnitude
        // through, so the dividend sign fixup restores the original dividend.
        quo_fix   = div_zero ? {WIDTH{1'b1}} :
                    ((sign_a ^ sign_b) ? (~div_quo_n + 1'b1) : div_quo_n);
        rem_fix   = sign_a ? (~div_rem_n + 1'b1) : div_rem_n;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = is_div ? DIV : MUL;
            MUL:     if (last_iter) state_next = IDLE;
            DIV:     if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            quo      <= '0;
            mag_b    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= CW'(WIDTH);
                        acc      <= '0;
                        quo      <= start_mag_a;
                        mag_b    <= start_mag_b;
                        sign_a   <= start_sign_a;
                        sign_b   <= start_sign_b;
                        div_zero <= is_div && (op_b == '0);
                    end
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                end
                MUL: begin
                    cnt <= cnt - 1'b1;
                    acc <= mul_hi_n;
                    quo <= mul_lo_n;
                    if (last_iter) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                DIV: begin
                    cnt <= cnt - 1'b1;
                    acc <= div_rem_n;
                    quo <= div_quo_n;
                    if (last_iter) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu_ex.sv
// rtl/alu_mdu_ex.sv - EX-stage ALU with single-cycle R-type ops, HI/LO access and iterative MDU
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   validEx     instruction in EX is real
//   funct, sa   R-type function code and shift amount
//   readRs      rs operand
//   outMuxEx    rt / forwarded operand
//   outAlu      combinational result, zeroAlu = (outAlu == 0)
//   stallEx     hold EX and earlier stages
//   mduBusy     iterative unit running
module alu_mdu_ex
    import alu_ex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validEx,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   sa,
    input  logic [WIDTH-1:0] readRs,
    input  logic [WIDTH-1:0] outMuxEx,
    output logic [WIDTH-1:0] outAlu,
    output logic             zeroAlu,
    output logic             stallEx,
    output logic             mduBusy
);

    logic             accept;
    logic             start;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [SHW-1:0]   shamt_v;

    assign stallEx = validEx && mduBusy && is_hilo_funct(funct);
    assign accept  = validEx && !stallEx;
    assign start   = accept && is_iter_funct(funct);
    assign mthi    = accept && (funct == F_MTHI);
    assign mtlo    = accept && (funct == F_MTLO);
    assign shamt_v = readRs[SHW-1:0];

    alu_mdu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_div   (funct[1]),
        .is_signed(!funct[0]),
        .op_a     (readRs),
        .op_b     (outMuxEx),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (readRs),
        .busy     (mduBusy),
        .hi       (hi),
        .lo       (lo)
    );

    always_comb begin
        outAlu = {WIDTH{1'b1}};
        case (funct)
            F_SLL:   outAlu = outMuxEx << sa;
            F_SRL:   outAlu = outMuxEx >> sa;
            F_SRA:   outAlu = $unsigned($signed(outMuxEx) >>> sa);
            F_SLLV:  outAlu = outMuxEx << shamt_v;
            F_SRLV:  outAlu = outMuxEx >> shamt_v;
            F_SRAV:  outAlu = $unsigned($signed(outMuxEx) >>> shamt_v);
            F_ADD,
            F_ADDU:  outAlu = readRs + outMuxEx;
            F_SUB,
            F_SUBU:  outAlu = readRs - outMuxEx;
            F_AND:   outAlu = readRs & outMuxEx;
            F_OR:    outAlu = readRs | outMuxEx;
            F_XOR:   outAlu = readRs ^ outMuxEx;
            F_NOR:   outAlu = ~(readRs | outMuxEx);
            F_SLT:   outAlu = WIDTH'($signed(readRs) < $signed(outMuxEx));
            F_SLTU:  outAlu = WIDTH'(readRs < outMuxEx);
            F_MFHI:  outAlu = hi;
            F_MFLO:  outAlu = lo;
            F_MTHI,
            F_MTLO,
            F_MULT,
            F_MULTU,
            F_DIV,
            F_DIVU:  outAlu = '0;
            default: outAlu = {WIDTH{1'b1}};
        endcase
    end

    assign zeroAlu = (outAlu == '0);

endmodule

// File: tb/tb_alu_mdu_ex.sv
// tb/tb_alu_mdu_ex.sv - directed self-checking bench for alu_mdu_ex
module tb_alu_mdu_ex;

    logic        clk;
    logic        rst_n;
    logic        validEx;
    logic [5:0]  funct;
    logic [4:0]  sa;
    logic [31:0] readRs;
    logic [31:0] outMuxEx;
    logic [31:0] outAlu;
    logic        zeroAlu;
    logic        stallEx;
    logic        mduBusy;

    int checks;
    int failures;

    alu_mdu_ex #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .validEx (validEx),
        .funct   (funct),
        .sa      (sa),
        .readRs  (readRs),
        .outMuxEx(outMuxEx),
        .outAlu  (outAlu),
        .zeroAlu (zeroAlu),
        .stallEx (stallEx),
        .mduBusy (mduBusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present an iterative op for one cycle, then drop validEx and wait for completion.
    task automatic run_iter(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        validEx = 1'b1; funct = f; readRs = a; outMuxEx = b;
        @(negedge clk);
        validEx = 1'b0; funct = 6'b000000;
        n = 0;
        while (mduBusy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mduBusy) begin
            failures++;
            $display("FAIL iter_timeout funct=%b busy=%b required=0", f, mduBusy);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi_v, output logic [31:0] lo_v);
        @(negedge clk);
        validEx = 1'b1; funct = 6'b010010;
        #1 lo_v = outAlu;
        funct = 6'b010000;
        #1 hi_v = outAlu;
        validEx = 1'b0; funct = 6'b000000;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; validEx = 1'b0; funct = 6'b0; sa = 5'd0; readRs = '0; outMuxEx = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (outAlu !== 32'h0 || zeroAlu !== 1'b1 || stallEx !== 1'b0 || mduBusy !== 1'b0) begin
            failures++;
            $display("FAIL reset got outAlu=%h zero=%b stall=%b busy=%b required 0/1/0/0",
                     outAlu, zeroAlu, stallEx, mduBusy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu;
        logic [5:0]  f_t [10];
        logic [4:0]  s_t [10];
        logic [31:0] a_t [10];
        logic [31:0] b_t [10];
        logic [31:0] e_t [10];
        f_t[0] = 6'b100001; s_t[0] = 0; a_t[0] = 32'h7FFFFFFF; b_t[0] = 32'h1;        e_t[0] = 32'h80000000;
        f_t[1] = 6'b100011; s_t[1] = 0; a_t[1] = 32'h5;        b_t[1] = 32'h5;        e_t[1] = 32'h0;
        f_t[2] = 6'b111111; s_t[2] = 0; a_t[2] = 32'h12;       b_t[2] = 32'h34;       e_t[2] = 32'hFFFFFFFF;
        f_t[3] = 6'b000111; s_t[3] = 0; a_t[3] = 32'h24;       b_t[3] = 32'h80000000; e_t[3] = 32'hF8000000;
        f_t[4] = 6'b101011; s_t[4] = 0; a_t[4] = 32'h1;        b_t[4] = 32'hFFFFFFFF; e_t[4] = 32'h1;
        f_t[5] = 6'b101010; s_t[5] = 0; a_t[5] = 32'h1;        b_t[5] = 32'hFFFFFFFF; e_t[5] = 32'h0;
        f_t[6] = 6'b000000; s_t[6] = 4; a_t[6] = 32'h0;        b_t[6] = 32'h0000000F; e_t[6] = 32'h000000F0;
        f_t[7] = 6'b000010; s_t[7] = 8; a_t[7] = 32'h0;        b_t[7] = 32'h80000000; e_t[7] = 32'h00800000;
        f_t[8] = 6'b000011; s_t[8] = 8; a_t[8] = 32'h0;        b_t[8] = 32'h80000000; e_t[8] = 32'hFF800000;
        f_t[9] = 6'b100111; s_t[9] = 0; a_t[9] = 32'hF0F0F0F0; b_t[9] = 32'h0F0F0000; e_t[9] = 32'h00000F0F;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            validEx = 1'b1; funct = f_t[i]; sa = s_t[i]; readRs = a_t[i]; outMuxEx = b_t[i];
            #1;
            checks++;
            if (outAlu !== e_t[i] || zeroAlu !== (e_t[i] == 32'h0) || stallEx !== 1'b0) begin
                failures++;
                $display("FAIL alu_vec%0d funct=%b got %h zero=%b stall=%b required %h", i, f_t[i],
                         outAlu, zeroAlu, stallEx, e_t[i]);
            end
        end
        validEx = 1'b0; funct = 6'b0; sa = 5'd0;
    endtask

    task automatic test_mult;
        int          stalls;
        logic [31:0] hv, lv;
        @(negedge clk);
        validEx = 1'b1; funct = 6'b011000; readRs = 32'hFFFFFFFD; outMuxEx = 32'd7;
        @(negedge clk);
        funct = 6'b010010;
        #1;
        stalls = 0;
        while (stallEx && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (stalls !== 32) begin
            failures++;
            $display("FAIL mult_stall_cycles got %0d required 32", stalls);
        end
        checks++;
        if (outAlu !== 32'hFFFFFFEB) begin
            failures++;
            $display("FAIL mult_lo got %h required FFFFFFEB", outAlu);
        end
        @(negedge clk);
        funct = 6'b010000;
        #1;
        checks++;
        if (outAlu !== 32'hFFFFFFFF || stallEx !== 1'b0) begin
            failures++;
            $display("FAIL mult_hi got %h stall=%b required FFFFFFFF", outAlu, stallEx);
        end
        validEx = 1'b0;
        run_iter(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        read_hilo(hv, lv);
        checks++;
        if (hv !== 32'hFFFFFFFE || lv !== 32'h00000001) begin
            failures++;
            $display("FAIL multu_max got hi=%h lo=%h required FFFFFFFE/00000001", hv, lv);
        end
    endtask

    task automatic test_div;
        logic [31:0] hv, lv;
        run_iter(6'b011010, 32'hFFFFFFF9, 32'd2);
        read_hilo(hv, lv);
        checks++;
        if (lv !== 32'hFFFFFFFD || hv !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL div_neg7_2 got hi=%h lo=%h required FFFFFFFF/FFFFFFFD", hv, lv);
        end
        run_iter(6'b011011, 32'd9, 32'd0);
        read_hilo(hv, lv);
        checks++;
        if (lv !== 32'hFFFFFFFF || hv !== 32'd9) begin
            failures++;
            $display("FAIL divu_by_zero got hi=%h lo=%h required 00000009/FFFFFFFF", hv, lv);
        end
        run_iter(6'b011010, 32'h80000000, 32'hFFFFFFFF);
        read_hilo(hv, lv);
        checks++;
        if (lv !== 32'h80000000 || hv !== 32'h0) begin
            failures++;
            $display("FAIL div_min_neg1 got hi=%h lo=%h required 00000000/80000000", hv, lv);
        end
        run_iter(6'b011010, 32'd100, 32'hFFFFFFF9);
        read_hilo(hv, lv);
        checks++;
        if (lv !== 32'hFFFFFFF2 || hv !== 32'd2) begin
            failures++;
            $display("FAIL div_100_neg7 got hi=%h lo=%h required 00000002/FFFFFFF2", hv, lv);
        end
    endtask

    task automatic test_back_to_back;
        int          stalls;
        logic [31:0] hv, lv;
        @(negedge clk);
        validEx = 1'b1; funct = 6'b011001; readRs = 32'd3; outMuxEx = 32'd4;
        @(negedge clk);
        funct = 6'b100001; readRs = 32'd2; outMuxEx = 32'd3;
        #1;
        checks++;
        if (stallEx !== 1'b0 || outAlu !== 32'd5 || mduBusy !== 1'b1) begin
            failures++;
            $display("FAIL indep_addu got out=%h stall=%b busy=%b required 5/0/1", outAlu, stallEx, mduBusy);
        end
        @(negedge clk);
        funct = 6'b011001; readRs = 32'd5; outMuxEx = 32'd6;
        #1;
        stalls = 0;
        while (stallEx && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        // One cycle went to the ADDU, so the second MULTU waits 31 cycles.
        checks++;
        if (stalls !== 31) begin
            failures++;
            $display("FAIL b2b_stall_cycles got %0d required 31", stalls);
        end
        @(negedge clk);
        validEx = 1'b0;
        #1;
        checks++;
        if (mduBusy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_issue busy=%b required 1", mduBusy);
        end
        run_iter(6'b000000, 32'd0, 32'd0);
        read_hilo(hv, lv);
        checks++;
        if (lv !== 32'd30 || hv !== 32'd0) begin
            failures++;
            $display("FAIL b2b_result got hi=%h lo=%h required 00000000/0000001E", hv, lv);
        end
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] hv, lv, lv0;
        read_hilo(hv, lv0);
        @(negedge clk);
        validEx = 1'b0; funct = 6'b010011; readRs = 32'h1234;
        read_hilo(hv, lv);
        checks++;
        if (lv !== lv0) begin
            failures++;
            $display("FAIL mtlo_invalid got lo=%h required %h", lv, lv0);
        end
        @(negedge clk);
        validEx = 1'b1; funct = 6'b010011; readRs = 32'h1234;
        @(negedge clk);
        funct = 6'b010001; readRs = 32'hABCD;
        @(negedge clk);
        funct = 6'b010010;
        #1;
        checks++;
        if (outAlu !== 32'h1234) begin
            failures++;
            $display("FAIL mtlo_mflo got %h required 00001234", outAlu);
        end
        funct = 6'b010000;
        #1;
        checks++;
        if (outAlu !== 32'hABCD) begin
            failures++;
            $display("FAIL mthi_mfhi got %h required 0000ABCD", outAlu);
        end
        validEx = 1'b0; funct = 6'b0;
    endtask

    task automatic test_reset_mid_div;
        logic [31:0] hv, lv;
        @(negedge clk);
        validEx = 1'b1; funct = 6'b011010; readRs = 32'd100; outMuxEx = 32'd7;
        @(negedge clk);
        validEx = 1'b0; funct = 6'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mduBusy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_div busy=%b required 0", mduBusy);
        end
        rst_n = 1'b1;
        read_hilo(hv, lv);
        checks++;
        if (hv !== 32'h0 || lv !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_div_hilo got hi=%h lo=%h required 0/0", hv, lv);
        end
        run_iter(6'b011001, 32'd3, 32'd4);
        read_hilo(hv, lv);
        checks++;
        if (lv !== 32'd12 || hv !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_multu got hi=%h lo=%h required 0/0000000C", hv, lv);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_back_to_back();
        test_mthi_mtlo();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
